// File: rtl/poly_pkg.sv
// Shared constants and types for the polynomial datapath.
package poly_pkg;

  localparam int unsigned DataWidth = 256;
  localparam int unsigned AddrWidth = 10;

  // BLS12-381 scalar field modulus.
  localparam logic [DataWidth-1:0] Modulus =
    256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/poly_sub_seq_if.sv
// Control handshake plus the A/B read ports and C write port of poly_sub_seq.
interface poly_sub_seq_if;
  import poly_pkg::*;

  logic                 start;
  logic [AddrWidth:0]   len;
  logic                 op;
  logic                 busy;
  logic                 done;
  logic                 a_rd_en;
  logic                 b_rd_en;
  logic [AddrWidth-1:0] a_addr;
  logic [AddrWidth-1:0] b_addr;
  logic [DataWidth-1:0] a_rdata;
  logic [DataWidth-1:0] b_rdata;
  logic                 c_wr_en;
  logic [AddrWidth-1:0] c_addr;
  logic [DataWidth-1:0] c_wdata;

  // Controller / RAM side.
  modport master (
    output start, len, op, a_rdata, b_rdata,
    input  busy, done, a_rd_en, b_rd_en, a_addr, b_addr, c_wr_en, c_addr, c_wdata
  );

  // Sequencer side.
  modport slave (
    input  start, len, op, a_rdata, b_rdata,
    output busy, done, a_rd_en, b_rd_en, a_addr, b_addr, c_wr_en, c_addr, c_wdata
  );

endinterface

// File: rtl/modular_substraction.sv
// Combinational d = (x - y) mod M for x, y < M.
module modular_substraction #(
  parameter int unsigned         Width = poly_pkg::DataWidth,
  parameter logic [Width-1:0]    M     = poly_pkg::Modulus
) (
  input  logic [Width-1:0] x,
  input  logic [Width-1:0] y,
  output logic [Width-1:0] d
);

  logic [Width:0]   diff;
  logic [Width-1:0] wrap;

  // Borrow selects the M-corrected value; carry of the correction is dropped.
  always_comb begin
    diff = {1'b0, x} - {1'b0, y};
    wrap = diff[Width-1:0] + M;
    d    = diff[Width] ? wrap : diff[Width-1:0];
  end

endmodule

// File: rtl/poly_sub_seq.sv
// Sequencer for coefficient-wise modular subtraction C[i] = A[i] - B[i] (or B[i] - A[i]).
module poly_sub_seq
  import poly_pkg::*;
(
  input logic          clk,
  input logic          rst,
  poly_sub_seq_if.slave bus
);

  localparam logic [AddrWidth:0] CntOne = 1;

  state_e               state_q, state_d;
  logic [AddrWidth:0]   len_q, len_d;
  logic [AddrWidth:0]   rd_cnt_q, rd_cnt_d;
  logic                 op_q, op_d;
  logic                 rd_en;
  logic [AddrWidth-1:0] rd_addr;
  logic                 busy, done;
  logic                 last_rd;

  logic                 s2_valid_q;
  logic [AddrWidth-1:0] s2_idx_q;
  logic                 wr_en_q;
  logic [AddrWidth-1:0] wr_addr_q;
  logic [DataWidth-1:0] wr_data_q;

  logic [DataWidth-1:0] sub_x, sub_y, sub_d;

  assign last_rd = (rd_cnt_q == (len_q - CntOne));

  // Next-state, counter and read-strobe logic.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    op_d     = op_q;
    rd_cnt_d = rd_cnt_q;
    rd_en    = 1'b0;
    rd_addr  = '0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          len_d    = bus.len;
          op_d     = bus.op;
          rd_cnt_d = '0;
          state_d  = (bus.len == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        busy     = 1'b1;
        rd_en    = 1'b1;
        rd_addr  = rd_cnt_q[AddrWidth-1:0];
        rd_cnt_d = rd_cnt_q + CntOne;
        if (last_rd) state_d = StDrain;
      end
      StDrain: begin
        busy = 1'b1;
        // Final write is on the bus and nothing is left behind it in S2.
        if (wr_en_q && !s2_valid_q) state_d = StDone;
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      len_q    <= '0;
      op_q     <= 1'b0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      op_q     <= op_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // S2 operand swap for B - A.
  assign sub_x = op_q ? bus.b_rdata : bus.a_rdata;
  assign sub_y = op_q ? bus.a_rdata : bus.b_rdata;

  modular_substraction #(
    .Width (DataWidth),
    .M     (Modulus)
  ) u_modsub (
    .x (sub_x),
    .y (sub_y),
    .d (sub_d)
  );

  // S1->S2 tag pipeline and S2->S3 result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_idx_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      s2_valid_q <= rd_en;
      s2_idx_q   <= rd_addr;
      wr_en_q    <= s2_valid_q;
      if (s2_valid_q) begin
        wr_addr_q <= s2_idx_q;
        wr_data_q <= sub_d;
      end
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.a_rd_en = rd_en;
  assign bus.b_rd_en = rd_en;
  assign bus.a_addr  = rd_addr;
  assign bus.b_addr  = rd_addr;
  assign bus.c_wr_en = wr_en_q;
  assign bus.c_addr  = wr_addr_q;
  assign bus.c_wdata = wr_data_q;

endmodule

// File: doc/poly_sub_seq.md
# poly_sub_seq

Sequencer that computes coefficient-wise modular subtraction of two polynomials, C[i] = (A[i] − B[i]) mod M (or B[i] − A[i]), for i = 0..len−1. It drives the read ports of two coefficient RAMs and the write port of a result RAM, and feeds one shared modular_substraction datapath through a fixed 3-stage pipeline. It sits in the poly_mul datapath next to the NTT/pointwise stages and is started by the top-level controller.

## Interface
- data_width, 256, coefficient width
- addr_width, 10, RAM address width; maximum length is 2^addr_width
- M, 256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001, modulus (BLS12-381 scalar field)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; accepted only in IDLE
- len  in  addr_width+1  number of coefficients, sampled on accepted start; 0..2^addr_width
- op  in  1  sampled on accepted start; 0: A−B, 1: B−A
- busy  out  1  high from the cycle after start is accepted through the done cycle
- done  out  1  one-cycle pulse at completion
- a_rd_en, b_rd_en  out  1  read strobes, asserted together
- a_addr, b_addr  out  addr_width  read address, same value on both
- a_rdata, b_rdata  in  data_width  read data, valid exactly 1 cycle after rd_en
- c_wr_en  out  1  result write strobe
- c_addr  out  addr_width  result address
- c_wdata  out  data_width  result value, in [0, M)

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: when start=1, latch len and op. If len=0, go to DONE. Otherwise go to READ with rd_cnt=0.
- READ: each cycle, assert rd_en with addr=rd_cnt and increment rd_cnt. After issuing the read with rd_cnt=len−1, go to DRAIN.
- DRAIN: no reads. Stay until the last write has been issued, then go to DONE.
- DONE: pulse done for one cycle, then return to IDLE.
- Pipeline stages:
  - S1: read issue.
  - S2: rdata arrives. Operands are swapped when op=1 and applied to modular_substraction. The result, index and valid bit are registered.
  - S3: the registered result drives c_wr_en, c_addr and c_wdata.
- Arithmetic: {borrow,d} = x − y over data_width+1 bits; if borrow, add M; the carry-out is discarded. Inputs must be < M (caller's precondition); outputs are then < M.
- start while busy is ignored and has no effect on the running job.
- len = 2^addr_width: rd_cnt spans the full address range, with no wrap before termination. The counter is addr_width+1 bits wide.
- Reset values: busy=0, done=0, rd_en=0, c_wr_en=0, addresses=0, c_wdata=0, FSM=IDLE, all pipeline valid bits=0.
- rst asserted mid-job: on the next edge everything returns to reset values. No write occurs in the cycle after rst is sampled high, and in-flight data is dropped.

## Timing
- Start accepted at cycle T.
- Read for index i is issued at T+1+i.
- Write for index i occurs at T+3+i, so latency from read to write is 2 cycles.
- Writes are back-to-back with no gaps, in ascending address order.
- The last write is at T+2+len. done pulses at T+3+len. busy is high T+1..T+3+len.
- len=0: no reads and no writes. busy is high at T+1 only, and done pulses at T+1.
- A new start is accepted at T+4+len (first IDLE cycle) at the earliest.
- Throughput is 1 coefficient per cycle.

## Structure
- Shared package poly_pkg holds:
  - the modulus M and data_width, so the package value matches the modular_substraction default;
  - the FSM state typedef (2-bit enum IDLE/READ/DRAIN/DONE).
- One sub-module: a single modular_substraction instance between S2 and S3. The controller FSM, counters and pipeline registers stay in this module.

## Test plan
- A=[5,7], B=[3,7], op=0, len=2 → writes C[0]=2 at T+3, C[1]=0 at T+4; done at T+5.
- A=[3], B=[5], op=0 → C[0]=M−2 (…fffffffe_ffffffff). With op=1 the same data → C[0]=2.
- A=[0], B=[M−1], op=0 → C[0]=1. A=[M−1], B=[0] → M−1.
- len=2^addr_width, random A,B < M → 1024 consecutive writes at addresses 0..1023, all matching the golden model; one done pulse.
- len=0 → no rd_en/wr_en; done at T+1. A start pulsed during a running job → ignored, and the done count is 1.
- rst asserted at T+5 of a len=8 job → no c_wr_en from T+6 on; all outputs at reset values; a fresh start afterwards completes correctly.
